// File: rtl/sha256_iter_core_if.sv
// Job and result handshake bundle for sha256_iter_core.
// The master side offers jobs and consumes results; the slave side is the core.
interface sha256_iter_core_if;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_state;
  logic [511:0] in_block;
  logic [8:0]   in_difficulty;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_hash;
  logic         out_meets_target;
  logic         busy;

  modport master (
    output flush, in_valid, in_state, in_block, in_difficulty, out_ready,
    input  in_ready, out_valid, out_hash, out_meets_target, busy
  );

  modport slave (
    input  flush, in_valid, in_state, in_block, in_difficulty, out_ready,
    output in_ready, out_valid, out_hash, out_meets_target, busy
  );
endinterface

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core computing UNROLL rounds per clock behind a valid/ready
// job port; returns the feed-forward hash and a leading-zero difficulty flag.
module sha256_iter_core #(
  parameter int unsigned UNROLL = 1
) (
  input logic               clk,
  input logic               rst_n,
  sha256_iter_core_if.slave bus
);

  localparam int unsigned CYCLES = 64 / UNROLL;
  localparam logic [6:0]  DoneRound = 7'(CYCLES * UNROLL);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16))
  begin : g_unroll_check
    $error("sha256_iter_core: UNROLL must be 1, 2, 4, 8 or 16");
  end

  localparam logic [31:0] RoundK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              out_meets_q;
  logic [255:0]      out_hash_q;
  logic [6:0]        round_q;
  logic [8:0]        diff_q;
  logic [7:0][31:0]  wk_q;     // working a..h, index 0 = a
  logic [7:0][31:0]  saved_q;  // chaining input kept for feed-forward
  logic [15:0][31:0] win_q;    // message schedule window, index 0 = current W

  logic [7:0][31:0]  wk_next;
  logic [15:0][31:0] win_next;
  logic [7:0][31:0]  hash_sum;
  logic [31:0]       t1;
  logic [31:0]       t2;
  logic [31:0]       w_new;
  logic [5:0]        k_idx;
  logic              meets;

  always_comb begin
    wk_next  = wk_q;
    win_next = win_q;
    t1       = '0;
    t2       = '0;
    w_new    = '0;
    k_idx    = '0;
    for (int r = 0; r < UNROLL; r++) begin
      k_idx = round_q[5:0] + 6'(r);
      t1 = wk_next[7] + bsig1(wk_next[4])
         + ((wk_next[4] & wk_next[5]) ^ (~wk_next[4] & wk_next[6]))
         + win_next[0] + RoundK[k_idx];
      t2 = bsig0(wk_next[0])
         + ((wk_next[0] & wk_next[1]) ^ (wk_next[0] & wk_next[2]) ^ (wk_next[1] & wk_next[2]));
      wk_next = {wk_next[6:4], wk_next[3] + t1, wk_next[2:0], t1 + t2};
      w_new = ssig1(win_next[14]) + win_next[9] + ssig0(win_next[1]) + win_next[0];
      win_next = {w_new, win_next[15:1]};
    end
  end

  // The feed-forward add runs in its own cycle, keeping it off the round adder chain.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      hash_sum[i] = saved_q[i] + wk_q[i];
    end
  end

  // Shifting by (256 - D) leaves only the top D bits; D=0 shifts everything out.
  assign meets = ((hash_sum >> (9'd256 - diff_q)) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_meets_q <= 1'b0;
      out_hash_q  <= '0;
      round_q     <= '0;
      diff_q      <= '0;
      wk_q        <= '0;
      saved_q     <= '0;
      win_q       <= '0;
    end else if (bus.flush) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      round_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            wk_q       <= bus.in_state;
            saved_q    <= bus.in_state;
            win_q      <= bus.in_block;
            diff_q     <= (bus.in_difficulty > 9'd256) ? 9'd256 : bus.in_difficulty;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            round_q    <= '0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (round_q == DoneRound) begin
            out_hash_q  <= hash_sum;
            out_meets_q <= meets;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            round_q     <= '0;
            state_q     <= StDone;
          end else begin
            wk_q    <= wk_next;
            win_q   <= win_next;
            round_q <= round_q + 7'(UNROLL);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.out_hash         = out_hash_q;
  assign bus.out_meets_target = out_meets_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_sha256_iter_core.sv
// Runs one core per legal UNROLL in lockstep on shared stimulus and checks each against a
// plain-arithmetic SHA-256 compression model.
module tb_sha256_iter_core;

  localparam int NCores = 5;
  localparam logic [NCores-1:0] AllOnes = '1;

  localparam logic [255:0] Iv = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                 32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [511:0] AbcBlock = {32'h00000018, 448'h0, 32'h61626380};
  localparam logic [255:0] AbcHash = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                      32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};

  localparam logic [31:0] TbK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [255:0] in_state = '0;
  logic [511:0] in_block = '0;
  logic [8:0]   in_difficulty = '0;

  logic         ov [NCores];
  logic         ir [NCores];
  logic         bz [NCores];
  logic         om [NCores];
  logic [255:0] oh [NCores];
  logic [NCores-1:0] ov_vec, ir_vec, bz_vec;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NCores; k++) begin : g_dut
    sha256_iter_core_if bus ();
    assign bus.flush         = flush;
    assign bus.in_valid      = in_valid;
    assign bus.in_state      = in_state;
    assign bus.in_block      = in_block;
    assign bus.in_difficulty = in_difficulty;
    assign bus.out_ready     = out_ready;
    assign ov[k] = bus.out_valid;
    assign ir[k] = bus.in_ready;
    assign bz[k] = bus.busy;
    assign om[k] = bus.out_meets_target;
    assign oh[k] = bus.out_hash;
    sha256_iter_core #(.UNROLL(1 << k)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  always_comb begin
    ov_vec = '0;
    ir_vec = '0;
    bz_vec = '0;
    for (int k = 0; k < NCores; k++) begin
      ov_vec[k] = ov[k];
      ir_vec[k] = ir[k];
      bz_vec[k] = bz[k];
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_hash(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = st[32*i +: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TbK[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[32*i +: 32] = st[32*i +: 32] + v[i];
    return res;
  endfunction

  function automatic logic ref_flag(input logic [255:0] h, input int d);
    int need = (d > 256) ? 256 : d;
    int lz = 0;
    while (lz < 256 && h[255-lz] == 1'b0) lz++;
    return lz >= need;
  endfunction

  // Waits for every core to be ready, then presents one job for exactly one accept edge.
  task automatic offer(input logic [255:0] st, input logic [511:0] blk, input logic [8:0] d);
    int waited = 0;
    while (ir_vec != AllOnes && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("offer_ready", 256'(ir_vec), 256'(AllOnes));
    in_state = st;
    in_block = blk;
    in_difficulty = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = {8{$urandom()}};
    in_block = {16{$urandom()}};
    in_difficulty = 9'($urandom());
  endtask

  // Called one step after the accept edge with out_ready high; checks latency and result.
  task automatic collect(input string tag, input logic [255:0] exp_h, input logic exp_f);
    int lat [NCores];
    logic got [NCores];
    logic [255:0] hh [NCores];
    logic ff [NCores];
    int cyc = 0;
    int ngot = 0;
    for (int k = 0; k < NCores; k++) begin
      lat[k] = -1; got[k] = 1'b0; hh[k] = '0; ff[k] = 1'b0;
    end
    while (ngot < NCores && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < NCores; k++) begin
        if (!got[k] && ov[k]) begin
          got[k] = 1'b1; lat[k] = cyc; hh[k] = oh[k]; ff[k] = om[k]; ngot++;
        end
      end
    end
    for (int k = 0; k < NCores; k++) begin
      check_eq($sformatf("%s_lat_u%0d", tag, 1 << k), 256'(lat[k]), 256'(64 / (1 << k) + 1));
      check_eq($sformatf("%s_hash_u%0d", tag, 1 << k), hh[k], exp_h);
      check_eq($sformatf("%s_flag_u%0d", tag, 1 << k), 256'(ff[k]), 256'(exp_f));
    end
    @(posedge clk); #1;
    check_eq($sformatf("%s_drain", tag), 256'(ov_vec), 256'(0));
  endtask

  task automatic random_job(input string tag);
    logic [255:0] st;
    logic [511:0] blk;
    int d;
    int opts [9] = '{0, 1, 2, 3, 4, 8, 256, 300, 0};
    for (int i = 0; i < 8; i++) st[32*i +: 32] = $urandom();
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom();
    opts[8] = int'($urandom_range(0, 511));
    d = opts[$urandom_range(0, 8)];
    offer(st, blk, 9'(d));
    collect(tag, ref_hash(st, blk), ref_flag(ref_hash(st, blk), d));
  endtask

  task automatic expect_quiet(input string tag, input int ncyc);
    int seen_valid = 0;
    int seen_busy = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (ov_vec != '0) seen_valid++;
      if (bz_vec != '0) seen_busy++;
    end
    check_eq({tag, "_no_valid"}, 256'(seen_valid), 256'(0));
    check_eq({tag, "_no_busy"}, 256'(seen_busy), 256'(0));
  endtask

  initial begin
    logic [255:0] st1, st2, hold_h [NCores];
    logic [511:0] blk1, blk2;
    int waited, unstable, ir_seen, bz_seen, nz;
    int bad_diffs [3] = '{1, 300, 256};

    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_out_valid", 256'(ov_vec), 256'(0));
    check_eq("rst_in_ready", 256'(ir_vec), 256'(0));
    check_eq("rst_busy", 256'(bz_vec), 256'(0));
    for (int k = 0; k < NCores; k++) begin
      check_eq($sformatf("rst_hash_u%0d", 1 << k), oh[k], 256'(0));
      check_eq($sformatf("rst_flag_u%0d", 1 << k), 256'(om[k]), 256'(0));
    end
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_in_ready", 256'(ir_vec), 256'(AllOnes));

    offer(Iv, AbcBlock, 9'd0);
    collect("abc_d0", AbcHash, 1'b1);
    foreach (bad_diffs[i]) begin
      offer(Iv, AbcBlock, 9'(bad_diffs[i]));
      collect($sformatf("abc_d%0d", bad_diffs[i]), AbcHash, 1'b0);
    end

    for (int j = 0; j < 6; j++) random_job($sformatf("rnd%0d", j));

    // Backpressure: results must hold and a second offered job must wait.
    for (int i = 0; i < 8; i++) st1[32*i +: 32] = $urandom();
    for (int i = 0; i < 16; i++) blk1[32*i +: 32] = $urandom();
    for (int i = 0; i < 8; i++) st2[32*i +: 32] = $urandom();
    for (int i = 0; i < 16; i++) blk2[32*i +: 32] = $urandom();
    out_ready = 1'b0;
    offer(st1, blk1, 9'd2);
    waited = 0;
    while (ov_vec != AllOnes && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("bp_all_valid", 256'(ov_vec), 256'(AllOnes));
    for (int k = 0; k < NCores; k++) begin
      hold_h[k] = oh[k];
      check_eq($sformatf("bp_hash1_u%0d", 1 << k), oh[k], ref_hash(st1, blk1));
    end
    in_state = st2; in_block = blk2; in_difficulty = 9'd0; in_valid = 1'b1;
    unstable = 0; ir_seen = 0; bz_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NCores; k++) if (oh[k] !== hold_h[k] || !ov[k]) unstable++;
      if (ir_vec != '0) ir_seen++;
      if (bz_vec != '0) bz_seen++;
    end
    check_eq("bp_stable", 256'(unstable), 256'(0));
    check_eq("bp_in_ready_low", 256'(ir_seen), 256'(0));
    check_eq("bp_not_accepted", 256'(bz_seen), 256'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_valid", 256'(ov_vec), 256'(0));
    check_eq("bp_release_ready", 256'(ir_vec), 256'(AllOnes));
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect("bp_job2", ref_hash(st2, blk2), 1'b1);

    // Flush on the tenth cycle of a job, with a competing in_valid.
    out_ready = 1'b0;
    offer(Iv, AbcBlock, 9'd0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; in_valid = 1'b1; in_state = st1; in_block = blk1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_valid", 256'(ov_vec), 256'(0));
    check_eq("flush_busy", 256'(bz_vec), 256'(0));
    check_eq("flush_ready", 256'(ir_vec), 256'(AllOnes));
    out_ready = 1'b1;
    expect_quiet("flush", 80);
    offer(Iv, AbcBlock, 9'd0);
    collect("post_flush", AbcHash, 1'b1);

    // Asynchronous reset pulse between clock edges.
    offer(st2, blk2, 9'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 256'(ov_vec), 256'(0));
    check_eq("arst_busy", 256'(bz_vec), 256'(0));
    check_eq("arst_ready", 256'(ir_vec), 256'(0));
    nz = 0;
    for (int k = 0; k < NCores; k++) if (oh[k] != '0) nz++;
    check_eq("arst_hash_zero", 256'(nz), 256'(0));
    #7 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("arst_rel_ready", 256'(ir_vec), 256'(AllOnes));
    expect_quiet("arst", 80);
    offer(Iv, AbcBlock, 9'd0);
    collect("post_arst", AbcHash, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
